// File: rtl/bpu_ras_ckpt.sv
// Checkpointed return-address stack for the frontend predictor.
// A speculative RAS is updated at prediction time and an architectural RAS at
// commit. Branch checkpoints (ptr, count, TOS data) live in a FIFO so that a
// mispredict can restore the speculative stack in one cycle; flush copies the
// architectural stack over the speculative one.
module bpu_ras_ckpt #(
   parameter int unsigned PLEN        = 32,
   parameter int unsigned RAS_DEPTH   = 16,
   parameter int unsigned CKPT_NUM    = 8,
   parameter int unsigned INSTR_BYTES = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        pred_valid_i,
   input  logic                        pred_is_call_i,
   input  logic                        pred_is_ret_i,
   input  logic [PLEN-1:0]             pred_pc_i,
   input  logic                        ckpt_alloc_i,
   output logic                        ckpt_ready_o,
   output logic [$clog2(CKPT_NUM)-1:0] ckpt_id_o,
   input  logic                        ckpt_free_i,
   input  logic                        recover_i,
   input  logic [$clog2(CKPT_NUM)-1:0] recover_id_i,
   input  logic                        commit_valid_i,
   input  logic                        commit_is_call_i,
   input  logic                        commit_is_ret_i,
   input  logic [PLEN-1:0]             commit_pc_i,
   input  logic                        flush_i,
   output logic [PLEN-1:0]             top_o,
   output logic                        top_valid_o,
   output logic [$clog2(CKPT_NUM):0]   ckpt_count_o
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
   localparam int unsigned IW = $clog2(CKPT_NUM);
   localparam int unsigned KW = IW + 1;

   typedef struct packed {
      logic [PW-1:0]   ptr;
      logic [CW-1:0]   cnt;
      logic            we;
      logic [PLEN-1:0] wdata;
   } ras_upd_t;

   // Pop (if non-empty) followed by push; the push overwrites the oldest
   // entry once the stack is full, count saturates at RAS_DEPTH.
   function automatic ras_upd_t ras_step(input logic [PW-1:0]   ptr,
                                         input logic [CW-1:0]   cnt,
                                         input logic            is_call,
                                         input logic            is_ret,
                                         input logic [PLEN-1:0] pc);
      ras_upd_t r;
      r.ptr   = ptr;
      r.cnt   = cnt;
      r.we    = 1'b0;
      r.wdata = pc + PLEN'(INSTR_BYTES);
      if (is_ret && (cnt != '0)) begin
         r.ptr = (ptr == '0) ? PW'(RAS_DEPTH - 1) : ptr - PW'(1);
         r.cnt = cnt - CW'(1);
      end
      if (is_call) begin
         r.ptr = (r.ptr == PW'(RAS_DEPTH - 1)) ? '0 : r.ptr + PW'(1);
         if (r.cnt != CW'(RAS_DEPTH)) r.cnt = r.cnt + CW'(1);
         r.we  = 1'b1;
      end
      return r;
   endfunction

   logic [PLEN-1:0] spec_data_q [RAS_DEPTH];
   logic [PLEN-1:0] spec_data_d [RAS_DEPTH];
   logic [PLEN-1:0] arch_data_q [RAS_DEPTH];
   logic [PLEN-1:0] arch_data_d [RAS_DEPTH];
   logic [PW-1:0]   spec_ptr_q, spec_ptr_d, arch_ptr_q, arch_ptr_d;
   logic [CW-1:0]   spec_cnt_q, spec_cnt_d, arch_cnt_q, arch_cnt_d;

   logic [PW-1:0]   ck_ptr_q  [CKPT_NUM];
   logic [PW-1:0]   ck_ptr_d  [CKPT_NUM];
   logic [CW-1:0]   ck_cnt_q  [CKPT_NUM];
   logic [CW-1:0]   ck_cnt_d  [CKPT_NUM];
   logic [PLEN-1:0] ck_data_q [CKPT_NUM];
   logic [PLEN-1:0] ck_data_d [CKPT_NUM];
   logic [IW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [KW-1:0]   ccnt_q, ccnt_d;

   ras_upd_t        pred_u, arch_u;
   logic            free_ok, rec_live;
   logic [IW-1:0]   head_f, rec_off;
   logic [KW-1:0]   cnt_f;

   // Next-state for both stacks and the checkpoint FIFO; flush > recover > pred/alloc.
   always_comb begin
      spec_data_d = spec_data_q;
      spec_ptr_d  = spec_ptr_q;
      spec_cnt_d  = spec_cnt_q;
      arch_data_d = arch_data_q;
      arch_ptr_d  = arch_ptr_q;
      arch_cnt_d  = arch_cnt_q;
      ck_ptr_d    = ck_ptr_q;
      ck_cnt_d    = ck_cnt_q;
      ck_data_d   = ck_data_q;
      head_d      = head_q;
      tail_d      = tail_q;
      ccnt_d      = ccnt_q;

      pred_u = ras_step(spec_ptr_q, spec_cnt_q, pred_is_call_i, pred_is_ret_i, pred_pc_i);
      arch_u = ras_step(arch_ptr_q, arch_cnt_q, commit_is_call_i, commit_is_ret_i, commit_pc_i);

      // Commit is never suppressed; flush below sees its result.
      if (commit_valid_i) begin
         arch_ptr_d = arch_u.ptr;
         arch_cnt_d = arch_u.cnt;
         if (arch_u.we) arch_data_d[arch_u.ptr] = arch_u.wdata;
      end

      // Free retires the head first, so recover judges liveness afterwards.
      free_ok  = ckpt_free_i && (ccnt_q != '0);
      head_f   = head_q + IW'(free_ok);
      cnt_f    = ccnt_q - KW'(free_ok);
      rec_off  = recover_id_i - head_f;
      rec_live = KW'(rec_off) < cnt_f;

      if (flush_i) begin
         spec_data_d = arch_data_d;
         spec_ptr_d  = arch_ptr_d;
         spec_cnt_d  = arch_cnt_d;
         head_d      = '0;
         tail_d      = '0;
         ccnt_d      = '0;
      end else if (recover_i && rec_live) begin
         spec_ptr_d  = ck_ptr_q[recover_id_i];
         spec_cnt_d  = ck_cnt_q[recover_id_i];
         spec_data_d[ck_ptr_q[recover_id_i]] = ck_data_q[recover_id_i];
         head_d      = head_f;
         tail_d      = recover_id_i + IW'(1);
         ccnt_d      = KW'(rec_off) + KW'(1);
      end else begin
         if (pred_valid_i) begin
            spec_ptr_d = pred_u.ptr;
            spec_cnt_d = pred_u.cnt;
            if (pred_u.we) spec_data_d[pred_u.ptr] = pred_u.wdata;
         end
         head_d = head_f;
         ccnt_d = cnt_f;
         // Snapshot is the post-branch speculative state.
         if (ckpt_alloc_i && (cnt_f != KW'(CKPT_NUM))) begin
            ck_ptr_d[tail_q]  = spec_ptr_d;
            ck_cnt_d[tail_q]  = spec_cnt_d;
            ck_data_d[tail_q] = spec_data_d[spec_ptr_d];
            tail_d            = tail_q + IW'(1);
            ccnt_d            = cnt_f + KW'(1);
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(RAS_DEPTH); i++) begin
            spec_data_q[i] <= '0;
            arch_data_q[i] <= '0;
         end
         for (int i = 0; i < int'(CKPT_NUM); i++) begin
            ck_ptr_q[i]  <= '0;
            ck_cnt_q[i]  <= '0;
            ck_data_q[i] <= '0;
         end
         spec_ptr_q <= '0;
         spec_cnt_q <= '0;
         arch_ptr_q <= '0;
         arch_cnt_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         ccnt_q     <= '0;
      end else begin
         spec_data_q <= spec_data_d;
         arch_data_q <= arch_data_d;
         ck_ptr_q    <= ck_ptr_d;
         ck_cnt_q    <= ck_cnt_d;
         ck_data_q   <= ck_data_d;
         spec_ptr_q  <= spec_ptr_d;
         spec_cnt_q  <= spec_cnt_d;
         arch_ptr_q  <= arch_ptr_d;
         arch_cnt_q  <= arch_cnt_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         ccnt_q      <= ccnt_d;
      end
   end

   assign top_valid_o  = (spec_cnt_q != '0);
   assign top_o        = top_valid_o ? spec_data_q[spec_ptr_q] : '0;
   assign ckpt_ready_o = (ccnt_q != KW'(CKPT_NUM));
   assign ckpt_id_o    = tail_q;
   assign ckpt_count_o = ccnt_q;

endmodule

// File: tb/tb_bpu_ras_ckpt.sv
// Directed bench for bpu_ras_ckpt with default parameters.
module tb_bpu_ras_ckpt;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pred_valid, pred_call, pred_ret;
   logic [31:0] pred_pc;
   logic        alloc, free_c, recover;
   logic [2:0]  recover_id;
   logic        commit_valid, commit_call, commit_ret;
   logic [31:0] commit_pc;
   logic        flush;
   logic        ready;
   logic [2:0]  ckpt_id;
   logic [31:0] top;
   logic        top_valid;
   logic [3:0]  ckpt_count;

   int n_chk  = 0;
   int n_fail = 0;

   bpu_ras_ckpt dut (
      .clk_i(clk), .rst_ni(rst_n),
      .pred_valid_i(pred_valid), .pred_is_call_i(pred_call), .pred_is_ret_i(pred_ret),
      .pred_pc_i(pred_pc),
      .ckpt_alloc_i(alloc), .ckpt_ready_o(ready), .ckpt_id_o(ckpt_id),
      .ckpt_free_i(free_c), .recover_i(recover), .recover_id_i(recover_id),
      .commit_valid_i(commit_valid), .commit_is_call_i(commit_call),
      .commit_is_ret_i(commit_ret), .commit_pc_i(commit_pc),
      .flush_i(flush), .top_o(top), .top_valid_o(top_valid), .ckpt_count_o(ckpt_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      pred_valid = 0; pred_call = 0; pred_ret = 0; pred_pc = '0;
      alloc = 0; free_c = 0; recover = 0; recover_id = '0;
      commit_valid = 0; commit_call = 0; commit_ret = 0; commit_pc = '0;
      flush = 0;
   endtask

   // Apply current inputs across one rising edge, sample 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic pred(input logic c, input logic r, input logic [31:0] pc);
      pred_valid = 1; pred_call = c; pred_ret = r; pred_pc = pc;
   endtask

   task automatic commit(input logic c, input logic r, input logic [31:0] pc);
      commit_valid = 1; commit_call = c; commit_ret = r; commit_pc = pc;
   endtask

   initial begin
      idle();
      rst_n = 0;
      #13;
      chk("rst_top", top, 0);
      chk("rst_valid", 32'(top_valid), 0);
      chk("rst_ready", 32'(ready), 1);
      chk("rst_id", 32'(ckpt_id), 0);
      chk("rst_count", 32'(ckpt_count), 0);
      rst_n = 1;
      @(posedge clk); #1;

      // Basic call/return
      pred(1, 0, 32'h100); cyc();
      chk("call1_top", top, 32'h104);
      pred(1, 0, 32'h200); cyc();
      chk("call2_top", top, 32'h204);
      pred(0, 1, 0); cyc();
      chk("ret1_top", top, 32'h104);
      pred(0, 1, 0); cyc();
      chk("ret2_valid", 32'(top_valid), 0);
      chk("ret2_top", top, 0);
      pred(0, 1, 0); cyc();
      chk("ret_empty_valid", 32'(top_valid), 0);
      pred(0, 0, 32'h555); cyc();
      chk("noflag_valid", 32'(top_valid), 0);

      // Saturation: 17 calls, oldest overwritten, 16 pops
      for (int k = 0; k <= 16; k++) begin
         pred(1, 0, 32'h1000 + 32'(8 * k)); cyc();
      end
      for (int k = 16; k >= 1; k--) begin
         chk("sat_pop_top", top, 32'h1004 + 32'(8 * k));
         pred(0, 1, 0); cyc();
      end
      chk("sat_empty_valid", 32'(top_valid), 0);

      // Checkpoint and recover
      chk("ck_id0", 32'(ckpt_id), 0);
      pred(1, 0, 32'h100); alloc = 1; cyc();
      chk("ck_id1", 32'(ckpt_id), 1);
      chk("ck_cnt1", 32'(ckpt_count), 1);
      pred(0, 1, 0); alloc = 1; cyc();
      chk("ck_cnt2", 32'(ckpt_count), 2);
      pred(1, 0, 32'h300); cyc();
      chk("ck_top300", top, 32'h304);
      recover = 1; recover_id = 0; pred(1, 0, 32'h900); alloc = 1; cyc();
      chk("rec_top", top, 32'h104);
      chk("rec_cnt", 32'(ckpt_count), 1);
      chk("rec_id", 32'(ckpt_id), 1);
      recover = 1; recover_id = 5; cyc();
      chk("rec_dead_cnt", 32'(ckpt_count), 1);
      chk("rec_dead_top", top, 32'h104);

      // Fill checkpoint FIFO
      for (int k = 0; k < 7; k++) begin
         alloc = 1; cyc();
      end
      chk("full_cnt", 32'(ckpt_count), 8);
      chk("full_ready", 32'(ready), 0);
      chk("full_id", 32'(ckpt_id), 0);
      alloc = 1; cyc();
      chk("full_alloc_cnt", 32'(ckpt_count), 8);
      chk("full_alloc_id", 32'(ckpt_id), 0);
      alloc = 1; free_c = 1; cyc();
      chk("allocfree_cnt", 32'(ckpt_count), 8);
      chk("allocfree_id", 32'(ckpt_id), 1);
      free_c = 1; recover = 1; recover_id = 1; cyc();
      chk("freerec_cnt", 32'(ckpt_count), 7);
      chk("freerec_id", 32'(ckpt_id), 1);
      chk("freerec_ready", 32'(ready), 1);
      recover = 1; recover_id = 4; cyc();
      chk("rec_mid_cnt", 32'(ckpt_count), 3);
      chk("rec_mid_id", 32'(ckpt_id), 5);

      // Flush to architectural state
      commit(1, 0, 32'h400); cyc();
      commit(1, 0, 32'h500); cyc();
      pred(1, 0, 32'hA00); cyc();
      pred(1, 0, 32'hB00); cyc();
      pred(1, 0, 32'hC00); cyc();
      chk("preflush_top", top, 32'hC04);
      flush = 1; alloc = 1; pred(1, 0, 32'hD00); cyc();
      chk("flush_top", top, 32'h504);
      chk("flush_ckcnt", 32'(ckpt_count), 0);
      chk("flush_id", 32'(ckpt_id), 0);
      pred(0, 1, 0); cyc();
      chk("flush_pop1", top, 32'h404);
      pred(0, 1, 0); cyc();
      chk("flush_pop2_valid", 32'(top_valid), 0);
      commit(1, 0, 32'h600); flush = 1; cyc();
      chk("commitflush_top", top, 32'h604);
      pred(0, 1, 0); cyc();
      chk("commitflush_pop", top, 32'h504);
      pred(1, 1, 32'h800); cyc();
      chk("callret_top", top, 32'h804);
      pred(0, 1, 0); cyc();
      chk("callret_pop", top, 32'h404);

      // Asynchronous reset between edges
      alloc = 1; cyc();
      alloc = 1; cyc();
      chk("prerst_cnt", 32'(ckpt_count), 2);
      #3;
      rst_n = 0;
      #1;
      chk("arst_top", top, 0);
      chk("arst_valid", 32'(top_valid), 0);
      chk("arst_ready", 32'(ready), 1);
      chk("arst_id", 32'(ckpt_id), 0);
      chk("arst_count", 32'(ckpt_count), 0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;
      chk("postrst_valid", 32'(top_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
